// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz raster constants shared by the VGA timing generator.
// Coordinates are 10 bits wide, enough for the 800x525 total raster.
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int H_VISIBLE_640 = 640;
    localparam int H_FRONT_640   = 16;
    localparam int H_SYNC_640    = 96;
    localparam int H_BACK_640    = 48;
    localparam int H_TOTAL_640   = H_VISIBLE_640 + H_FRONT_640
                                 + H_SYNC_640 + H_BACK_640;

    localparam int V_VISIBLE_480 = 480;
    localparam int V_FRONT_480   = 10;
    localparam int V_SYNC_480    = 2;
    localparam int V_BACK_480    = 33;
    localparam int V_TOTAL_480   = V_VISIBLE_480 + V_FRONT_480
                                 + V_SYNC_480 + V_BACK_480;

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping raster axis counter; resets to its last value so the first
// increment lands on zero. wrap is combinational to chain the next axis.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int TOTAL = H_TOTAL_640
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    input  logic               inc,
    output logic [COORD_W-1:0] count,
    output logic               wrap
);

    localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

    assign wrap = ena && inc && (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= LAST;
        end else if (ena && inc) begin
            count <= wrap ? '0 : count + COORD_W'(1);
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// Free-running VGA timing generator: pixel divider, x/y counters,
// registered decode, sync delay line and frame counter.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = H_VISIBLE_640,
    parameter int H_FRONT   = H_FRONT_640,
    parameter int H_SYNC    = H_SYNC_640,
    parameter int H_BACK    = H_BACK_640,
    parameter int V_VISIBLE = V_VISIBLE_480,
    parameter int V_FRONT   = V_FRONT_480,
    parameter int V_SYNC    = V_SYNC_480,
    parameter int V_BACK    = V_BACK_480,
    parameter int CLK_DIV   = 1,
    parameter int SYNC_DLY  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    output logic [COORD_W-1:0] xcoor,
    output logic [COORD_W-1:0] ycoor,
    output logic               video_active,
    output logic               hsync,
    output logic               vsync,
    output logic               pix_tick,
    output logic               line_start,
    output logic               frame_start,
    output logic [7:0]         frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_VISIBLE);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_VISIBLE);
    localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_VISIBLE + H_FRONT);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_VISIBLE + V_FRONT);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0]   div;
    logic               h_wrap;
    logic               v_wrap;
    logic               adv;
    logic [COORD_W-1:0] x_nx;
    logic [COORD_W-1:0] y_nx;
    logic               hs_raw;
    logic               vs_raw;

    // A tick swallowed by ena=0 is replayed on resume by rewinding the divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div      <= '0;
            pix_tick <= 1'b0;
        end else if (ena) begin
            pix_tick <= (div == '0);
            div      <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
        end else begin
            pix_tick <= 1'b0;
            if (pix_tick) div <= '0;
        end
    end

    vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .inc   (pix_tick),
        .count (xcoor),
        .wrap  (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .inc   (h_wrap),
        .count (ycoor),
        .wrap  (v_wrap)
    );

    assign adv  = ena && pix_tick;
    assign x_nx = h_wrap ? '0 : (adv ? xcoor + COORD_W'(1) : xcoor);
    assign y_nx = v_wrap ? '0 : (h_wrap ? ycoor + COORD_W'(1) : ycoor);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            video_active <= 1'b0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
            hs_raw       <= 1'b1;
            vs_raw       <= 1'b1;
            frame_count  <= '0;
        end else if (ena) begin
            video_active <= (x_nx < H_VIS) && (y_nx < V_VIS);
            line_start   <= (x_nx == '0);
            frame_start  <= (x_nx == '0) && (y_nx == '0);
            hs_raw       <= !((x_nx >= HS_BEG) && (x_nx < HS_END));
            vs_raw       <= !((y_nx >= VS_BEG) && (y_nx < VS_END));
            if (v_wrap) frame_count <= frame_count + 8'd1;
        end
    end

    generate
        if (SYNC_DLY == 0) begin : g_no_dly
            assign hsync = hs_raw;
            assign vsync = vs_raw;
        end else begin : g_dly
            logic [SYNC_DLY-1:0] hs_pipe;
            logic [SYNC_DLY-1:0] vs_pipe;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hs_pipe <= '1;
                    vs_pipe <= '1;
                end else if (ena) begin
                    hs_pipe <= (hs_pipe << 1) | SYNC_DLY'(hs_raw);
                    vs_pipe <= (vs_pipe << 1) | SYNC_DLY'(vs_raw);
                end
            end

            assign hsync = hs_pipe[SYNC_DLY-1];
            assign vsync = vs_pipe[SYNC_DLY-1];
        end
    endgenerate

endmodule
